adc_capture: RTL

//  Triggered capture buffer between the ADC sampling path and the SPI slave.

---
 rtl/adc_capture.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture.sv
// Triggered ADC capture buffer: keeps one DEPTH-sample record around a level-crossing
// trigger, with a programmable pre-trigger window, and streams it out one byte per rd_next.
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              rd_next,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_PRE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              edge_q, edge_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  post_rem_q, post_rem_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_count_q, rd_count_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              has_prev_q, has_prev_d;
    logic              busy_q, busy_d;
    logic              trig_q, trig_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;
    logic              wr_en;
    logic              hit;
    logic [ADDR_W-1:0] pre_clamped;
    logic [CNT_W-1:0]  post_rem_first;

    always_comb begin
        pre_clamped    = ({1'b0, pretrig} > MAX_PRE) ? MAX_PRE[ADDR_W-1:0] : pretrig;
        post_rem_first = DEPTH_C - {1'b0, pre_q} - CNT_W'(1);
        hit = 1'b0;
        if (has_prev_q && sample_valid) begin
            if (edge_q)
                hit = (prev_q > level_q) && (sample_data <= level_q);
            else
                hit = (prev_q < level_q) && (sample_data >= level_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        edge_d      = edge_q;
        pre_d       = pre_q;
        wr_ptr_d    = wr_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_rem_d  = post_rem_q;
        trig_addr_d = trig_addr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_count_d  = rd_count_q;
        prev_d      = prev_q;
        has_prev_d  = has_prev_q;
        busy_d      = busy_q;
        trig_d      = trig_q;
        done_d      = done_q;
        wr_en       = 1'b0;
        rd_data_d   = (state_q == S_DONE) ? mem_rd_q : rd_data_q;

        // arm overrides everything, including a sample or read strobe in the same cycle
        if (arm) begin
            level_d    = trig_level;
            edge_d     = trig_edge;
            pre_d      = pre_clamped;
            state_d    = (pre_clamped == '0) ? S_WAIT : S_PRE;
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_rem_d = '0;
            has_prev_d = 1'b0;
            busy_d     = 1'b1;
            trig_d     = 1'b0;
            done_d     = 1'b0;
        end else begin
            if (sample_valid && (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST)) begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                prev_d     = sample_data;
                has_prev_d = 1'b1;
            end
            case (state_q)
                S_PRE: begin
                    if (sample_valid) begin
                        pre_cnt_d = pre_cnt_q + ADDR_W'(1);
                        if (pre_cnt_q + ADDR_W'(1) == pre_q)
                            state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        trig_d      = 1'b1;
                        post_rem_d  = post_rem_first;
                        if (post_rem_first == '0) begin
                            state_d    = S_DONE;
                            rd_ptr_d   = wr_ptr_q - pre_q;
                            rd_count_d = '0;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_valid) begin
                        post_rem_d = post_rem_q - CNT_W'(1);
                        if (post_rem_q == CNT_W'(1)) begin
                            state_d    = S_DONE;
                            rd_ptr_d   = trig_addr_q - pre_q;
                            rd_count_d = '0;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_next) begin
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        rd_count_d = rd_count_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            edge_q      <= 1'b0;
            pre_q       <= '0;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_rem_q  <= '0;
            trig_addr_q <= '0;
            rd_ptr_q    <= '0;
            rd_count_q  <= '0;
            prev_q      <= '0;
            has_prev_q  <= 1'b0;
            busy_q      <= 1'b0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            edge_q      <= edge_d;
            pre_q       <= pre_d;
            wr_ptr_q    <= wr_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_rem_q  <= post_rem_d;
            trig_addr_q <= trig_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_count_q  <= rd_count_d;
            prev_q      <= prev_d;
            has_prev_q  <= has_prev_d;
            busy_q      <= busy_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Buffer RAM is never reset; readout goes through two register stages
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= sample_data;
        mem_rd_q <= mem[rd_ptr_q];
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign triggered = trig_q;
    assign done      = done_q;
endmodule
